// File: rtl/btn_debounce_shot_if.sv
// Button bus: raw push-button pins in, debounced levels and one-clock press pulses out.
// The master drives the raw pins; the debouncer sits on the slave side.
interface btn_debounce_shot_if;
    logic [2:0] btn_raw;
    logic [2:0] btn_stable;
    logic [2:0] btn_stable_shot;

    modport master (
        output btn_raw,
        input  btn_stable,
        input  btn_stable_shot
    );

    modport slave (
        input  btn_raw,
        output btn_stable,
        output btn_stable_shot
    );
endinterface

// File: rtl/btn_debounce_shot.sv
// Three-channel push-button debouncer with a registered one-clock press pulse per channel.
// Each channel has its own two-flop synchronizer, saturating counter, and rising-edge detector.
module btn_debounce_shot #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_WIDTH       = 20,
    parameter bit          BTN_ACTIVE_LOW  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    btn_debounce_shot_if.slave   bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]           INV_MASK = BTN_ACTIVE_LOW ? 3'b111 : 3'b000;

    logic [2:0]           sync1_q,      sync1_d;
    logic [2:0]           sync2_q,      sync2_d;
    logic [2:0]           stable_q,     stable_d;
    logic [2:0]           stable_dly_q, stable_dly_d;
    logic [2:0]           shot_q,       shot_d;
    logic [CNT_WIDTH-1:0] cnt_q [3];
    logic [CNT_WIDTH-1:0] cnt_d [3];

    // Next-state logic: synchronizer shift, per-channel debounce counters, press edge detect.
    always_comb begin
        sync1_d      = bus.btn_raw ^ INV_MASK;
        sync2_d      = sync1_q;
        stable_d     = stable_q;
        stable_dly_d = stable_q;
        // Shot trails the stable rise by one edge so it is a clean registered pulse.
        shot_d       = stable_q & ~stable_dly_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = {CNT_WIDTH{1'b0}};
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = {CNT_WIDTH{1'b0}};
            end else if (cnt_q[i] >= CNT_MAX) begin
                // Saturating compare keeps the counter from ever wrapping.
                cnt_d[i]    = {CNT_WIDTH{1'b0}};
                stable_d[i] = sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    // State registers; asynchronous reset returns every channel to "not pressed".
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= 3'b000;
            sync2_q      <= 3'b000;
            stable_q     <= 3'b000;
            stable_dly_q <= 3'b000;
            shot_q       <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= {CNT_WIDTH{1'b0}};
            end
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            shot_q       <= shot_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.btn_stable      = stable_q;
    assign bus.btn_stable_shot = shot_q;

endmodule

// File: tb/tb_btn_debounce_shot.sv
// Directed bench for btn_debounce_shot with DEBOUNCE_CYCLES=4: a vector table for the
// active-high instance plus hand sequences for active-low inputs and asynchronous reset.
module tb_btn_debounce_shot;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    typedef struct {
        logic [2:0] raw;
        logic [2:0] stable;
        logic [2:0] shot;
    } vec_t;

    vec_t vecs[$];

    btn_debounce_shot_if bus_h ();
    btn_debounce_shot_if bus_l ();

    btn_debounce_shot #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(3), .BTN_ACTIVE_LOW(1'b0)) dut_h (
        .clk (clk),
        .rst (rst),
        .bus (bus_h)
    );

    btn_debounce_shot #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(3), .BTN_ACTIVE_LOW(1'b1)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bus_l)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // One clock: inputs were set at a falling edge, outputs are sampled at the next falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add_vec(input logic [2:0] r, input logic [2:0] s, input logic [2:0] sh);
        vec_t v;
        v.raw    = r;
        v.stable = s;
        v.shot   = sh;
        vecs.push_back(v);
    endtask

    // Settled channel sees a new raw level at edge 1: stable changes at edge 6, a press shot follows edge 7.
    task automatic add_seg(input logic [2:0] r, input int n, input logic [2:0] st_before,
                           input logic [2:0] st_after, input logic [2:0] shot_m);
        for (int k = 1; k <= n; k++) begin
            add_vec(r, (k < 6) ? st_before : st_after, (k == 7) ? shot_m : 3'b000);
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst           = 1'b1;
        bus_h.btn_raw = 3'b000;
        bus_l.btn_raw = 3'b111;

        // Reset state, before any clock edge and while clocks run in reset.
        #1 rst = 1'b0;
        #2;
        check("reset stable_h", bus_h.btn_stable, 3'b000);
        check("reset shot_h", bus_h.btn_stable_shot, 3'b000);
        check("reset stable_l", bus_l.btn_stable, 3'b000);
        check("reset shot_l", bus_l.btn_stable_shot, 3'b000);
        step();
        step();
        check("reset held stable_h", bus_h.btn_stable, 3'b000);
        check("reset held stable_l", bus_l.btn_stable, 3'b000);
        rst = 1'b1;

        // Vector table for the active-high instance.
        add_seg(3'b000, 3, 3'b000, 3'b000, 3'b000);
        add_seg(3'b001, 10, 3'b000, 3'b001, 3'b001);
        add_seg(3'b000, 9, 3'b001, 3'b000, 3'b000);
        for (int g = 0; g < 5; g++) begin
            add_vec(3'b010, 3'b000, 3'b000);
            add_vec(3'b010, 3'b000, 3'b000);
            add_vec(3'b010, 3'b000, 3'b000);
            add_vec(3'b000, 3'b000, 3'b000);
        end
        add_seg(3'b000, 4, 3'b000, 3'b000, 3'b000);
        add_seg(3'b011, 10, 3'b000, 3'b011, 3'b011);
        add_seg(3'b000, 9, 3'b011, 3'b000, 3'b000);
        add_seg(3'b001, 9, 3'b000, 3'b001, 3'b001);
        add_seg(3'b000, 9, 3'b001, 3'b000, 3'b000);
        add_seg(3'b001, 9, 3'b000, 3'b001, 3'b001);
        add_seg(3'b000, 9, 3'b001, 3'b000, 3'b000);

        for (int i = 0; i < vecs.size(); i++) begin
            bus_h.btn_raw = vecs[i].raw;
            step();
            check($sformatf("vec[%0d] stable_h", i), bus_h.btn_stable, vecs[i].stable);
            check($sformatf("vec[%0d] shot_h", i), bus_h.btn_stable_shot, vecs[i].shot);
            check($sformatf("vec[%0d] idle_l", i), bus_l.btn_stable | bus_l.btn_stable_shot, 3'b000);
        end

        // Active-low instance: bit0 pin pulled low, then released back high.
        bus_l.btn_raw = 3'b110;
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("al press k%0d stable", k), bus_l.btn_stable, (k >= 6) ? 3'b001 : 3'b000);
            check($sformatf("al press k%0d shot", k), bus_l.btn_stable_shot, (k == 7) ? 3'b001 : 3'b000);
        end
        bus_l.btn_raw = 3'b111;
        for (int k = 1; k <= 9; k++) begin
            step();
            check($sformatf("al rel k%0d stable", k), bus_l.btn_stable, (k >= 6) ? 3'b000 : 3'b001);
            check($sformatf("al rel k%0d shot", k), bus_l.btn_stable_shot, 3'b000);
        end

        // Bit2 held, reset pulsed with the counter at 2.
        bus_h.btn_raw = 3'b100;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("b2 pre k%0d stable", k), bus_h.btn_stable, 3'b000);
        end
        rst = 1'b0;
        #1;
        check("midcount rst stable", bus_h.btn_stable, 3'b000);
        check("midcount rst shot", bus_h.btn_stable_shot, 3'b000);
        step();
        rst = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("b2 post k%0d stable", k), bus_h.btn_stable, (k >= 6) ? 3'b100 : 3'b000);
            check($sformatf("b2 post k%0d shot", k), bus_h.btn_stable_shot, (k == 7) ? 3'b100 : 3'b000);
        end

        // Reset while the shot is high must drop it at once.
        rst = 1'b0;
        #1;
        check("midshot rst shot", bus_h.btn_stable_shot, 3'b000);
        check("midshot rst stable", bus_h.btn_stable, 3'b000);
        step();
        check("midshot held shot", bus_h.btn_stable_shot, 3'b000);
        rst = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("b2 again k%0d stable", k), bus_h.btn_stable, (k >= 6) ? 3'b100 : 3'b000);
            check($sformatf("b2 again k%0d shot", k), bus_h.btn_stable_shot, (k == 7) ? 3'b100 : 3'b000);
        end

        bus_h.btn_raw = 3'b000;
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("final stable_h", bus_h.btn_stable, 3'b000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
